// File: rtl/core_trace_ctrl.sv
// core_trace_ctrl: controls a core's reset and run window, and captures
// the IF/ID instruction stream into a first-word-fall-through trace buffer.
// A run ends on the halt opcode or on the cycle budget. When a run ends the
// core goes back into reset and the trace buffer stays readable.
module core_trace_ctrl #(
    parameter int DATA_W     = 32,
    parameter int PC_W       = 32,
    parameter int RST_CYCLES = 10,
    parameter int MAX_CYCLES = 100,
    parameter int DEPTH      = 16,
    parameter logic [DATA_W-1:0] HALT_INST = {DATA_W{1'b1}}
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            restart,
    input  logic                            inst_vld_i,
    input  logic [DATA_W-1:0]               inst_i,
    input  logic [PC_W-1:0]                 pc_i,
    input  logic                            rd_en,
    output logic                            core_rst,
    output logic                            running,
    output logic                            done,
    output logic                            halted,
    output logic                            timeout,
    output logic                            overflow,
    output logic [$clog2(MAX_CYCLES+1)-1:0] cycle_cnt,
    output logic [DATA_W-1:0]               rd_inst,
    output logic [PC_W-1:0]                 rd_pc,
    output logic                            empty,
    output logic                            full,
    output logic [$clog2(DEPTH):0]          count
);
    localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = DATA_W + PC_W;

    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] CYC_LAST  = CW'(MAX_CYCLES - 1);
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_HOLD, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic            halted_q, halted_d;
    logic            timeout_q, timeout_d;
    logic            ovf_q, ovf_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;

    logic [EW-1:0]   trace_mem [DEPTH];
    logic [EW-1:0]   head_w;

    logic            in_run, full_w, empty_w, pop, wr_en, is_halt, is_limit;

    // Buffer status and capture/pop qualification for this cycle.
    always_comb begin
        in_run   = (state_q == S_RUN);
        full_w   = (count_q == DEPTH_C);
        empty_w  = (count_q == '0);
        pop      = rd_en & ~empty_w;
        // A full buffer still accepts a capture when the head leaves in the same cycle.
        wr_en    = in_run & inst_vld_i & (~full_w | rd_en);
        is_halt  = in_run & inst_vld_i & (inst_i == HALT_INST);
        is_limit = in_run & (cyc_q == CYC_LAST);
    end

    // Next-state logic: run-control FSM plus buffer pointer bookkeeping.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        cyc_d      = cyc_q;
        halted_d   = halted_q;
        timeout_d  = timeout_q;
        ovf_d      = ovf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
        if (in_run && inst_vld_i && !wr_en) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = S_RUN;
                    hold_cnt_d = '0;
                    cyc_d      = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            S_RUN: begin
                // Halt has priority over timeout; the terminating cycle does not count up.
                if (is_halt) begin
                    state_d  = S_DONE;
                    halted_d = 1'b1;
                end else if (is_limit) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            S_DONE: begin
                // Restart wipes the run result and the buffer, overriding any pop this cycle.
                if (restart) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = '0;
                    cyc_d      = '0;
                    halted_d   = 1'b0;
                    timeout_d  = 1'b0;
                    ovf_d      = 1'b0;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    count_d    = '0;
                end
            end
            default: state_d = S_HOLD;
        endcase
    end

    // Control and status registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_HOLD;
            hold_cnt_q <= '0;
            cyc_q      <= '0;
            halted_q   <= 1'b0;
            timeout_q  <= 1'b0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            cyc_q      <= cyc_d;
            halted_q   <= halted_d;
            timeout_q  <= timeout_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Trace storage; contents need no reset because reads are masked while empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            trace_mem[wr_ptr_q] <= {inst_i, pc_i};
        end
    end

    // Head entry is shown without a read strobe and forced to zero while empty.
    always_comb begin
        head_w  = empty_w ? '0 : trace_mem[rd_ptr_q];
        rd_inst = head_w[EW-1:PC_W];
        rd_pc   = head_w[PC_W-1:0];
    end

    assign core_rst  = (state_q != S_RUN);
    assign running   = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign halted    = halted_q;
    assign timeout   = timeout_q;
    assign overflow  = ovf_q;
    assign cycle_cnt = cyc_q;
    assign empty     = empty_w;
    assign full      = full_w;
    assign count     = count_q;

endmodule

// File: doc/core_trace_ctrl.md
CORE_TRACE_CTRL -- requirements
Module: core_trace_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning instruction width.
REQ-002 SHALL have parameter PC_W, default 32, meaning PC width.
REQ-003 SHALL have parameter RST_CYCLES, default 10, meaning core reset hold length in clocks (>=1).
REQ-004 SHALL have parameter MAX_CYCLES, default 100, meaning run timeout in clocks (>=1).
REQ-005 SHALL have parameter DEPTH, default 16, meaning trace buffer entries (power of 2, >=2).
REQ-006 SHALL have parameter HALT_INST, default all-ones of DATA_W, meaning halt opcode.
REQ-007 SHALL have ports, in order:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- restart  in  1  in DONE, begin a new run.
- inst_vld_i  in  1  IF/ID instruction valid.
- inst_i  in  DATA_W  IF/ID instruction.
- pc_i  in  PC_W  IF/ID PC.
- rd_en  in  1  pop trace head.
- core_rst  out  1  active-high reset to core.
- running  out  1  FSM in RUN.
- done  out  1  FSM in DONE.
- halted  out  1  run ended by HALT_INST.
- timeout  out  1  run ended by MAX_CYCLES.
- overflow  out  1  sticky, a capture was dropped.
- cycle_cnt  out  $clog2(MAX_CYCLES+1)  RUN cycles elapsed.
- rd_inst  out  DATA_W  head instruction (first-word-fall-through).
- rd_pc  out  PC_W  head PC.
- empty  out  1  buffer empty.
- full  out  1  buffer full.
- count  out  $clog2(DEPTH)+1  entries held.

Function
REQ-008 SHALL implement FSM states HOLD, RUN, DONE; all transitions on rising clk.
REQ-009 SHALL in HOLD drive core_rst=1, count RST_CYCLES clocks, then enter RUN; core_rst=0 from first RUN cycle.
REQ-010 SHALL in RUN increment cycle_cnt by 1 per clock, starting at 0 on RUN entry.
REQ-011 SHALL in RUN, when inst_vld_i=1, write {inst_i, pc_i} to buffer tail if not full, or if full with rd_en=1 same cycle (count unchanged).
REQ-012 SHALL, when inst_vld_i=1 in RUN and write cannot be accepted, drop it and set overflow=1 until reset or restart.
REQ-013 SHALL ignore inst_vld_i outside RUN.
REQ-014 SHALL, on inst_vld_i=1 with inst_i==HALT_INST in RUN, capture it per REQ-011/012, set halted=1, enter DONE next cycle.
REQ-015 SHALL, when cycle_cnt==MAX_CYCLES-1 in RUN without halt, set timeout=1, enter DONE next cycle.
REQ-016 SHALL on simultaneous halt and timeout set halted=1, timeout=0.
REQ-017 SHALL in DONE drive core_rst=1, freeze cycle_cnt, hold halted/timeout, keep buffer readable.
REQ-018 SHALL on restart=1 in DONE clear halted, timeout, overflow, cycle_cnt, buffer, and enter HOLD; restart ignored in HOLD/RUN.
REQ-019 SHALL present head entry on rd_inst/rd_pc whenever empty=0; rd_en=1 pops it; rd_en while empty ignored, no state change.
REQ-020 SHALL allow rd_en in any state; pointers wrap modulo DEPTH.
REQ-021 SHALL keep full=(count==DEPTH), empty=(count==0).

Reset
REQ-022 SHALL on rst=0, asynchronously: state=HOLD, core_rst=1, running=0, done=0, halted=0, timeout=0, overflow=0, cycle_cnt=0, count=0, empty=1, full=0, rd_inst=0, rd_pc=0.
REQ-023 SHALL begin HOLD counting on first rising clk after rst deasserts; rst assertion mid-RUN aborts the run and clears buffer.

Verification
REQ-024 Defaults, rst released at t0 -> core_rst=1 for exactly 10 clocks, then running=1, cycle_cnt 0,1,2....
REQ-025 inst_vld_i every RUN cycle, pc 0,4,8,...; no halt -> after 100 RUN cycles timeout=1, done=1, cycle_cnt=99, full=1, overflow=1, head pc=0.
REQ-026 5 valid instrs then HALT_INST at pc=0x14 -> halted=1, timeout=0, count=6, pops return pc 0x0..0x14 in order, then empty=1.
REQ-027 Buffer full, inst_vld_i and rd_en same cycle -> count stays 16, overflow stays 0, new entry at tail.
REQ-028 HALT_INST on cycle_cnt=99 -> halted=1, timeout=0; then restart=1 -> HOLD, all flags 0, count=0, core_rst=1 for 10 clocks.
REQ-029 rst=0 asserted mid-RUN with count=3 -> same cycle core_rst=1, count=0, empty=1, running=0.
